// File: rtl/pio_master.sv
// PIO bus initiator: one host command at a time becomes a PIO strobe, an ack wait and a response pulse.
// Optional ack timeout is compiled in with `define PIO_MASTER_TIMEOUT_EN.
module pio_master #(
  parameter int DATA_W        = 32,
  parameter int TIMEOUT_NBITS = 8,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_din,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic              reg_ms,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q;
  logic              cmd_ready_q;
  logic              wr_q;
  logic [DATA_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_din_q;
  logic              reg_rd_q;
  logic              reg_wr_q;
  logic              reg_ms_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

`ifdef PIO_MASTER_TIMEOUT_EN
  localparam logic [TIMEOUT_NBITS-1:0] TICKS_C = TIMEOUT_NBITS'(TIMEOUT_TICKS);
  logic [TIMEOUT_NBITS-1:0] cnt_q;
  logic                     rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {31'(TIMEOUT_TICKS ^ TIMEOUT_NBITS), clk_div};
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_ms_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef PIO_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef PIO_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            wr_q        <= cmd_wr;
            reg_addr_q  <= cmd_addr;
            reg_din_q   <= cmd_wdata;
            reg_wr_q    <= cmd_wr;
            reg_rd_q    <= ~cmd_wr;
            reg_ms_q    <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
`ifdef PIO_MASTER_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Ack is checked first so an ack arriving with the final tick still wins.
          if (mem_ack) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? '0 : mem_rdata;
            reg_ms_q    <= 1'b0;
            state_q     <= S_DRAIN;
          end
`ifdef PIO_MASTER_TIMEOUT_EN
          else if (cnt_q == TICKS_C) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '1;
            reg_ms_q    <= 1'b0;
            state_q     <= S_DRAIN;
          end else if (clk_div) begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          // The responder holds ack until its next tick; leaving early would let the
          // next command see this stale ack.
          if (!mem_ack) begin
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          reg_ms_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign reg_addr  = reg_addr_q;
  assign reg_din   = reg_din_q;
  assign reg_rd    = reg_rd_q;
  assign reg_wr    = reg_wr_q;
  assign reg_ms    = reg_ms_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
